// File: rtl/two_traffic_lights_pkg.sv
// Shared types and lamp encodings for the two-light junction controller.
package two_traffic_lights_pkg;

  typedef enum logic [2:0] {
    S0 = 3'd0,  // ALL_RED_A
    S1 = 3'd1,  // A_RED_AMBER
    S2 = 3'd2,  // A_GREEN
    S3 = 3'd3,  // A_AMBER
    S4 = 3'd4,  // ALL_RED_B
    S5 = 3'd5,  // B_RED_AMBER
    S6 = 3'd6,  // B_GREEN
    S7 = 3'd7   // B_AMBER
  } state_t;

  typedef enum logic [1:0] {
    PH_RED       = 2'd0,
    PH_RED_AMBER = 2'd1,
    PH_GREEN     = 2'd2,
    PH_AMBER     = 2'd3
  } phase_t;

  localparam logic [2:0] RED       = 3'b100;
  localparam logic [2:0] RED_AMBER = 3'b110;
  localparam logic [2:0] GREEN     = 3'b001;
  localparam logic [2:0] AMBER     = 3'b010;

endpackage

// File: rtl/two_traffic_lights_light_phase_decode.sv
// Maps a light phase to its lamp pattern; an inactive light always shows RED.
module light_phase_decode
  import two_traffic_lights_pkg::*;
(
  input  logic       active,
  input  phase_t     phase,
  output logic [2:0] lamps
);

  // Phase to lamp pattern
  always_comb begin
    lamps = RED;
    if (active) begin
      case (phase)
        PH_RED:       lamps = RED;
        PH_RED_AMBER: lamps = RED_AMBER;
        PH_GREEN:     lamps = GREEN;
        PH_AMBER:     lamps = AMBER;
        default:      lamps = RED;
      endcase
    end else begin
      lamps = RED;
    end
  end

endmodule

// File: rtl/two_traffic_lights.sv
// Self-running eight-state controller alternating two UK-sequence lights with
// an all-red phase between handovers. Lamp outputs are registered.
module two_traffic_lights
  import two_traffic_lights_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] lightsA,
  output logic [2:0] lightsB
);

  state_t     state_q, state_d;
  phase_t     phase_d;
  logic       a_active_d;
  logic [2:0] lights_a_d, lights_b_d;
  logic [2:0] lights_a_q, lights_b_q;

  // Next-state sequencing
  always_comb begin
    state_d = S0;
    case (state_q)
      S0:      state_d = S1;
      S1:      state_d = S2;
      S2:      state_d = S3;
      S3:      state_d = S4;
      S4:      state_d = S5;
      S5:      state_d = S6;
      S6:      state_d = S7;
      S7:      state_d = S0;
      default: state_d = S0;
    endcase
  end

  // Lamps are decoded from the next state so the registered outputs line up
  // with the state register after every edge.
  always_comb begin
    phase_d    = PH_RED;
    a_active_d = 1'b1;
    case (state_d)
      S0: begin phase_d = PH_RED;       a_active_d = 1'b1; end
      S1: begin phase_d = PH_RED_AMBER; a_active_d = 1'b1; end
      S2: begin phase_d = PH_GREEN;     a_active_d = 1'b1; end
      S3: begin phase_d = PH_AMBER;     a_active_d = 1'b1; end
      S4: begin phase_d = PH_RED;       a_active_d = 1'b0; end
      S5: begin phase_d = PH_RED_AMBER; a_active_d = 1'b0; end
      S6: begin phase_d = PH_GREEN;     a_active_d = 1'b0; end
      S7: begin phase_d = PH_AMBER;     a_active_d = 1'b0; end
      default: begin phase_d = PH_RED;  a_active_d = 1'b1; end
    endcase
  end

  light_phase_decode u_decode_a (
    .active (a_active_d),
    .phase  (phase_d),
    .lamps  (lights_a_d)
  );

  light_phase_decode u_decode_b (
    .active (~a_active_d),
    .phase  (phase_d),
    .lamps  (lights_b_d)
  );

  // State and lamp registers with synchronous reset to all-red
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S0;
      lights_a_q <= RED;
      lights_b_q <= RED;
    end else begin
      state_q    <= state_d;
      lights_a_q <= lights_a_d;
      lights_b_q <= lights_b_d;
    end
  end

  assign lightsA = lights_a_q;
  assign lightsB = lights_b_q;

endmodule

// File: tb/tb_two_traffic_lights.sv
// Randomised self-checking bench for two_traffic_lights against a cycle-position model.
module tb_two_traffic_lights;

  logic       clk;
  logic       rst;
  logic [2:0] lightsA;
  logic [2:0] lightsB;

  int checks;
  int errors;
  int pos;  // model: cycles since last reset edge, modulo the 8-cycle period

  two_traffic_lights dut (
    .clk     (clk),
    .rst     (rst),
    .lightsA (lightsA),
    .lightsB (lightsB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] lamp_of(input int ph);
    case (ph)
      0:       return 3'b100;
      1:       return 3'b110;
      2:       return 3'b001;
      3:       return 3'b010;
      default: return 3'b111;
    endcase
  endfunction

  // Light A runs its sequence in the first half of the period, B in the second.
  function automatic logic [2:0] exp_a(input int p);
    return (p >= 1 && p <= 3) ? lamp_of(p) : 3'b100;
  endfunction

  function automatic logic [2:0] exp_b(input int p);
    return (p >= 5 && p <= 7) ? lamp_of(p - 4) : 3'b100;
  endfunction

  task automatic step(input logic r);
    rst = r;
    @(posedge clk);
    #1;
    pos = r ? 0 : (pos + 1) % 8;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      step(1'b1);
      checks++;
      if (lightsA !== 3'b100 || lightsB !== 3'b100) begin
        errors++;
        $display("FAIL reset_hold: got A=%b B=%b, expected A=100 B=100", lightsA, lightsB);
      end
    end
  endtask

  task automatic test_full_sequence;
    logic [5:0] table_seq [8];
    table_seq[0] = {3'b110, 3'b100};
    table_seq[1] = {3'b001, 3'b100};
    table_seq[2] = {3'b010, 3'b100};
    table_seq[3] = {3'b100, 3'b100};
    table_seq[4] = {3'b100, 3'b110};
    table_seq[5] = {3'b100, 3'b001};
    table_seq[6] = {3'b100, 3'b010};
    table_seq[7] = {3'b100, 3'b100};
    for (int i = 0; i < 9; i++) begin
      step(1'b0);
      checks++;
      if ({lightsA, lightsB} !== table_seq[i % 8]) begin
        errors++;
        $display("FAIL full_seq[%0d]: got A=%b B=%b, expected %b", i, lightsA, lightsB, table_seq[i % 8]);
      end
    end
  endtask

  task automatic test_wrap;
    logic [5:0] seen [17];
    step(1'b1);
    for (int i = 0; i < 17; i++) begin
      step(1'b0);
      seen[i] = {lightsA, lightsB};
      checks++;
      if (lightsA !== exp_a(pos) || lightsB !== exp_b(pos)) begin
        errors++;
        $display("FAIL wrap_model[%0d]: got A=%b B=%b, expected A=%b B=%b",
                 i, lightsA, lightsB, exp_a(pos), exp_b(pos));
      end
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (seen[i + 8] !== seen[i]) begin
        errors++;
        $display("FAIL wrap_period[%0d]: got %b, expected %b", i + 8, seen[i + 8], seen[i]);
      end
    end
  endtask

  task automatic test_mid_reset;
    int budget;
    budget = 0;
    while (pos != 6 && budget < 20) begin
      step(1'b0);
      budget++;
    end
    checks++;
    if (lightsA !== 3'b100 || lightsB !== 3'b001) begin
      errors++;
      $display("FAIL mid_reset_s6: got A=%b B=%b, expected A=100 B=001", lightsA, lightsB);
    end
    step(1'b1);
    checks++;
    if (lightsA !== 3'b100 || lightsB !== 3'b100) begin
      errors++;
      $display("FAIL mid_reset_hit: got A=%b B=%b, expected A=100 B=100", lightsA, lightsB);
    end
    step(1'b0);
    checks++;
    if (lightsA !== 3'b110 || lightsB !== 3'b100) begin
      errors++;
      $display("FAIL mid_reset_release: got A=%b B=%b, expected A=110 B=100", lightsA, lightsB);
    end
  endtask

  task automatic test_random_safety;
    logic r;
    for (int i = 0; i < 60; i++) begin
      r = ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0;
      step(r);
      checks++;
      if (lightsA !== exp_a(pos) || lightsB !== exp_b(pos)) begin
        errors++;
        $display("FAIL random_model[%0d]: got A=%b B=%b, expected A=%b B=%b (rst=%b)",
                 i, lightsA, lightsB, exp_a(pos), exp_b(pos), r);
      end
      checks++;
      if (lightsA !== 3'b100 && lightsB !== 3'b100) begin
        errors++;
        $display("FAIL safety[%0d]: got A=%b B=%b, expected at least one 100", i, lightsA, lightsB);
      end
      checks++;
      if (!(lightsA inside {3'b100, 3'b110, 3'b001, 3'b010}) ||
          !(lightsB inside {3'b100, 3'b110, 3'b001, 3'b010})) begin
        errors++;
        $display("FAIL legal_lamps[%0d]: got A=%b B=%b, expected values in {100,110,001,010}",
                 i, lightsA, lightsB);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    pos    = 0;
    rst    = 1'b1;
    test_reset();
    test_full_sequence();
    test_wrap();
    test_mid_reset();
    test_random_safety();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/two_traffic_lights.md
Name: two_traffic_lights

Overview:
- Controller for two traffic lights (A, B) at one junction, using the UK sequence red, red+amber, green, amber, red.
- The two lights take turns; an all-red phase separates each handover, so both lights are never non-red at the same time.
- Self-running Moore FSM, one state per clock cycle, no external inputs besides clock/reset.
- Sits as a leaf block driving lamp outputs directly.

Parameters:
- none (fixed one-cycle dwell per state)

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset; one clock; reset is synchronous and active-high
- lightsA  output  3  light A lamps, bit2=red, bit1=amber, bit0=green
- lightsB  output  3  light B lamps, same encoding as lightsA

Behaviour:
- Lamp encodings: RED=3'b100, RED_AMBER=3'b110, GREEN=3'b001, AMBER=3'b010. No other values are ever driven.
- State register: 8 states, advances exactly one state per rising clk edge while rst=0.
- Outputs are a pure function of the current state (Moore, no combinational path from rst). Output changes coincide with the state change after the edge.
- State table, as (lightsA, lightsB), next state:
  - S0 ALL_RED_A (100,100) -> S1
  - S1 A_RED_AMBER (110,100) -> S2
  - S2 A_GREEN (001,100) -> S3
  - S3 A_AMBER (010,100) -> S4
  - S4 ALL_RED_B (100,100) -> S5
  - S5 B_RED_AMBER (100,110) -> S6
  - S6 B_GREEN (100,001) -> S7
  - S7 B_AMBER (100,010) -> S0, wrap-around
- Period is 8 cycles.
- Reset:
  - rst=1 sampled at a rising edge forces S0, so outputs become (100,100) after that edge.
  - Reset holds S0 for as long as rst stays high.
  - The first edge with rst=0 moves S0 to S1.
- Reset mid-operation from any state returns to S0 on the next edge; there is no partial sequence completion.
- Safety invariant, every cycle: at least one of lightsA/lightsB equals RED.
- Before the first reset edge, the state is don't-care. Any unreachable/illegal state encoding recovers to S0 on the next edge (default branch).
- Latency: reset deassertion to first non-red A lamp is 1 edge.

Decomposition:
- Package two_traffic_lights_pkg holds:
  - typedef enum logic [2:0] state_t (S0..S7 names as above)
  - lamp constants RED, RED_AMBER, GREEN, AMBER (logic [2:0]).
- One optional sub-module, light_phase_decode: maps a 2-bit phase (red, red_amber, green, amber) to 3-bit lamps. It is instantiated twice, with the non-active light forced to RED.
- The FSM itself stays in the top module.

Test Plan:
- Reset hold: rst=1 for 2 edges -> (lightsA,lightsB)=(100,100) after each reset edge.
- Full sequence: release rst, then sample each edge -> (110,100),(001,100),(010,100),(100,100),(100,110),(100,001),(100,010),(100,100), then repeating (110,100)...
- Wrap-around: run 16+ cycles after reset -> the pattern repeats with period 8 exactly; the cycle-9 sample equals the cycle-1 sample.
- Mid-sequence reset: assert rst=1 for one edge while in S6 (100,001) -> (100,100) next edge; after release, (110,100) on the following edge.
- Safety check: every cycle across 40 cycles with random reset pulses -> lightsA==100 or lightsB==100 always, and no output outside {100,110,001,010}.
